// File: rtl/arb_pkg.sv
// Shared types, widths and the rotating-priority pick for the 4-way round-robin arbiter.
package arb_pkg;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Hold counter must represent 0..max_hold; never narrower than one bit.
  function automatic int cnt_width(input int max_hold);
    int w;
    w = $clog2(max_hold + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Returns {found, id}: first set bit of r scanning p+1, p+2, p+3, p (mod 4).
  function automatic logic [ID_W:0] rr_pick(input logic [N_REQ-1:0] r,
                                            input logic [ID_W-1:0]  p);
    logic [ID_W:0]   res;
    logic [ID_W-1:0] idx;
    res = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = p + ID_W'(k);
      if (!res[ID_W] && r[idx]) begin
        res = {1'b1, idx};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter4_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req,
    input  gnt,
    input  gnt_id,
    input  gnt_valid,
    input  timeout
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_id,
    output gnt_valid,
    output timeout
  );

endinterface

// File: rtl/decoder2to4.sv
// 2:4 one-hot decoder with enable; purely combinational.
module decoder2to4 (
  input  logic       en,
  input  logic [1:0] a,
  output logic [3:0] y
);

  assign y = en ? (4'b0001 << a) : 4'b0000;

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with hold limit; 1-cycle request-to-grant, registered outputs.
// A holder keeps the grant while requesting, unless MAX_HOLD cycles elapse with another requester waiting.
module rr_arbiter4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  rr_arbiter4_if.slave       bus
);

  localparam int              CNT_W   = cnt_width(MAX_HOLD);
  localparam bit              LIMITED = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_HOLD);

  state_t           state;
  logic [ID_W-1:0]  gnt_id_q;
  logic             gnt_valid_q;
  logic             timeout_q;
  logic [ID_W-1:0]  ptr;
  logic [CNT_W-1:0] cnt;

  logic [N_REQ-1:0] holder_mask;
  logic [N_REQ-1:0] cand;
  logic [ID_W:0]    pick;
  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic             holder_req;
  logic             at_limit;

  // The current holder never competes in its own rotation or handoff scan.
  assign holder_mask = gnt_valid_q ? ({{(N_REQ-1){1'b0}}, 1'b1} << gnt_id_q) : '0;
  assign cand        = bus.req & ~holder_mask;
  assign pick        = rr_pick(cand, ptr);
  assign win_found   = pick[ID_W];
  assign win_id      = pick[ID_W-1:0];
  assign holder_req  = bus.req[gnt_id_q];
  assign at_limit    = LIMITED && (cnt == MAX_CNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      ptr         <= ID_W'(N_REQ - 1);
      cnt         <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            state       <= GRANT;
            gnt_id_q    <= win_id;
            gnt_valid_q <= 1'b1;
            ptr         <= win_id;
            cnt         <= CNT_W'(1);
          end
        end
        GRANT: begin
          if (holder_req) begin
            if (at_limit && win_found) begin
              gnt_id_q  <= win_id;
              ptr       <= win_id;
              cnt       <= CNT_W'(1);
              timeout_q <= 1'b1;
            end else if (LIMITED && !at_limit) begin
              cnt <= cnt + 1'b1;
            end
          end else if (win_found) begin
            gnt_id_q <= win_id;
            ptr      <= win_id;
            cnt      <= CNT_W'(1);
          end else begin
            state       <= IDLE;
            gnt_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          gnt_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.timeout   = timeout_q;

  decoder2to4 u_dec (
    .en (gnt_valid_q),
    .a  (gnt_id_q),
    .y  (bus.gnt)
  );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Directed and randomized checks of rr_arbiter4 against a behavioural round-robin model.
module tb_rr_arbiter4;

  localparam int MAXH = 8;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  rr_arbiter4_if bus ();

  rr_arbiter4 #(.MAX_HOLD(MAXH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: whole-number bookkeeping of who holds the resource and for how long.
  bit m_valid;
  int m_id;
  int m_ptr;
  int m_held;
  bit m_to;

  function automatic int m_pick(input logic [3:0] r, input int p, input int excl);
    for (int k = 1; k <= 4; k++) begin
      int id;
      id = (p + k) % 4;
      if (r[id] && id != excl) return id;
    end
    return -1;
  endfunction

  task automatic model(input logic [3:0] r, input logic rs);
    int w;
    if (rs) begin
      m_valid = 0; m_id = 0; m_ptr = 3; m_held = 0; m_to = 0;
      return;
    end
    m_to = 0;
    if (!m_valid) begin
      w = m_pick(r, m_ptr, -1);
      if (w >= 0) begin
        m_valid = 1; m_id = w; m_ptr = w; m_held = 1;
      end
    end else if (r[m_id]) begin
      w = m_pick(r, m_ptr, m_id);
      if (MAXH != 0 && m_held >= MAXH && w >= 0) begin
        m_id = w; m_ptr = w; m_held = 1; m_to = 1;
      end else if (MAXH != 0 && m_held < MAXH) begin
        m_held++;
      end
    end else begin
      w = m_pick(r, m_ptr, m_id);
      if (w >= 0) begin
        m_id = w; m_ptr = w; m_held = 1;
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [3:0] exp_gnt;
    exp_gnt = m_valid ? (4'b0001 << m_id) : 4'b0000;
    check("gnt", 32'(bus.gnt), 32'(exp_gnt));
    check("gnt_valid", 32'(bus.gnt_valid), 32'(m_valid));
    check("timeout", 32'(bus.timeout), 32'(m_to));
    if (m_valid) check("gnt_id", 32'(bus.gnt_id), 32'(m_id));
    check("onehot0", 32'($onehot0(bus.gnt)), 32'd1);
    if (bus.gnt_valid) check("gnt_decode", 32'(bus.gnt), 32'(4'b0001 << bus.gnt_id));
  endtask

  // Apply inputs just after an edge, let the next edge sample them, then compare.
  task automatic cyc(input logic [3:0] r, input logic rs);
    bus.req = r;
    rst     = rs;
    @(posedge clk);
    model(r, rs);
    #1;
    compare_all();
  endtask

  initial begin
    int tcount;
    logic [3:0] rq;
    logic [3:0] seq_req [5];
    logic [3:0] seq_gnt [5];
    checks = 0;
    errors = 0;
    bus.req = 4'b0000;
    rst = 1'b1;

    // Reset state
    cyc(4'b0000, 1'b1);
    cyc(4'b0000, 1'b1);
    check("reset_gnt", 32'(bus.gnt), 32'd0);
    check("reset_timeout", 32'(bus.timeout), 32'd0);

    // All requesting, each holder drops one cycle after its grant
    seq_req = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111};
    seq_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 5; i++) begin
      cyc(seq_req[i], 1'b0);
      check("rr_order", 32'(bus.gnt), 32'(seq_gnt[i]));
    end
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);

    // Sole requester past the hold limit keeps its grant
    tcount = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(4'b0100, 1'b0);
      if (bus.timeout) tcount++;
    end
    check("sole_gnt", 32'(bus.gnt), 32'(4'b0100));
    check("sole_no_timeout", 32'(tcount), 32'd0);
    cyc(4'b0000, 1'b0);

    // Two contenders rotate every MAXH cycles
    tcount = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(4'b0011, 1'b0);
      if (i == 7)  check("limit_hold0", 32'(bus.gnt), 32'(4'b0001));
      if (i == 8)  check("limit_switch", 32'(bus.gnt), 32'(4'b0010));
      if (i == 8)  check("limit_timeout", 32'(bus.timeout), 32'd1);
      if (i == 9)  check("timeout_clear", 32'(bus.timeout), 32'd0);
      if (i == 16) check("limit_back0", 32'(bus.gnt), 32'(4'b0001));
      if (bus.timeout) tcount++;
    end
    check("limit_timeout_count", 32'(tcount), 32'd4);
    cyc(4'b0000, 1'b0);

    // Holder 2 releases while 0 and 3 wait: hand off to 3 with no idle cycle
    cyc(4'b0100, 1'b0);
    check("h2_gnt", 32'(bus.gnt), 32'(4'b0100));
    cyc(4'b1001, 1'b0);
    check("handoff_gnt", 32'(bus.gnt), 32'(4'b1000));
    check("handoff_valid", 32'(bus.gnt_valid), 32'd1);

    // Reset mid-grant, then the first grant restarts at requester 0
    cyc(4'b1111, 1'b0);
    cyc(4'b1111, 1'b0);
    cyc(4'b1111, 1'b1);
    check("rst_mid_gnt", 32'(bus.gnt), 32'd0);
    check("rst_mid_valid", 32'(bus.gnt_valid), 32'd0);
    cyc(4'b1111, 1'b0);
    check("post_rst_gnt", 32'(bus.gnt), 32'(4'b0001));

    // Randomized traffic with sticky requests and occasional resets
    rq = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom_range(0, 15));
      cyc(rq, ($urandom_range(0, 63) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
